// File: rtl/cpu_hazard_ctrl.sv
// Hazard controller: multi-source operand forwarding, load-use and MDU interlocks,
// redirect flushing and saturating performance counters.
module cpu_hazard_ctrl #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned FWD_N   = 2,
  parameter int unsigned SEL_W   = $clog2(FWD_N + 1),
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [REG_AW-1:0]       rd1_num,
  input  logic [REG_AW-1:0]       rd2_num,
  input  logic                    rd1_used,
  input  logic                    rd2_used,
  input  logic                    id_uses_mdu,
  input  logic [FWD_N*REG_AW-1:0] wr_num,
  input  logic [FWD_N-1:0]        wr_en,
  input  logic [FWD_N-1:0]        wr_late,
  input  logic                    mdu_start,
  input  logic                    redirect,
  input  logic                    redirect_jump,
  output logic [SEL_W-1:0]        fwd1_sel,
  output logic [SEL_W-1:0]        fwd2_sel,
  output logic [4:0]              stalls,
  output logic [4:0]              flushs,
  output logic                    mdu_busy,
  output logic [CNT_W-1:0]        data_hazard_count,
  output logic [CNT_W-1:0]        fwd_count,
  output logic [CNT_W-1:0]        stall_count,
  output logic [CNT_W-1:0]        control_hazard_count,
  output logic [CNT_W-1:0]        branch_count,
  output logic [CNT_W-1:0]        jump_count,
  output logic [CNT_W-1:0]        mdu_stall_count
);

  localparam int unsigned MC_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam int unsigned NCNT = 7;

  typedef enum logic [0:0] {StIdle, StBusy} mdu_state_e;

  mdu_state_e        state_q, state_d;
  logic [MC_W-1:0]   mdu_cnt_q, mdu_cnt_d;

  logic              hit1, hit2, late1, late2;
  logic [SEL_W-1:0]  win1, win2;
  logic              lu, mdu_stall, stall_any;
  logic [NCNT-1:0]   cnt_inc;
  logic [CNT_W-1:0]  cnt_q [NCNT];

  // Scan oldest to youngest so the lowest-numbered matching source ends up winning.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    late1 = 1'b0;
    late2 = 1'b0;
    win1  = '0;
    win2  = '0;
    for (int k = FWD_N - 1; k >= 0; k--) begin
      if (rd1_used && wr_en[k] && (wr_num[k*REG_AW +: REG_AW] == rd1_num) && (rd1_num != '0)) begin
        hit1  = 1'b1;
        late1 = wr_late[k];
        win1  = SEL_W'(k + 1);
      end
      if (rd2_used && wr_en[k] && (wr_num[k*REG_AW +: REG_AW] == rd2_num) && (rd2_num != '0)) begin
        hit2  = 1'b1;
        late2 = wr_late[k];
        win2  = SEL_W'(k + 1);
      end
    end
  end

  assign mdu_busy  = (state_q == StBusy);
  assign lu        = (hit1 & late1) | (hit2 & late2);
  assign mdu_stall = mdu_busy & id_uses_mdu;
  assign stall_any = (lu | mdu_stall) & ~redirect;

  // All pipeline controls are forced idle while reset is held.
  always_comb begin
    fwd1_sel = '0;
    fwd2_sel = '0;
    stalls   = 5'b00000;
    flushs   = 5'b00000;
    if (clr) begin
      if (hit1 && !late1) fwd1_sel = win1;
      if (hit2 && !late2) fwd2_sel = win2;
      if (stall_any) stalls = 5'b00011;
      flushs[1] = redirect;
      flushs[2] = redirect | stall_any;
    end
  end

  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mdu_start) begin
          state_d   = StBusy;
          mdu_cnt_d = MC_W'(MDU_LAT - 1);
        end
      end
      StBusy: begin
        if (mdu_start) begin
          mdu_cnt_d = MC_W'(MDU_LAT - 1);
        end else if (mdu_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          mdu_cnt_d = mdu_cnt_q - MC_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q   <= StIdle;
      mdu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  always_comb begin
    cnt_inc    = '0;
    cnt_inc[0] = (hit1 | hit2) & ~redirect;
    cnt_inc[1] = (fwd1_sel != '0) | (fwd2_sel != '0);
    cnt_inc[2] = stall_any;
    cnt_inc[3] = redirect;
    cnt_inc[4] = redirect & ~redirect_jump;
    cnt_inc[5] = redirect & redirect_jump;
    cnt_inc[6] = mdu_stall & ~redirect;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCNT; i++) begin
      if (!clr) begin
        cnt_q[i] <= '0;
      end else if (cnt_inc[i] && (cnt_q[i] != '1)) begin
        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign data_hazard_count    = cnt_q[0];
  assign fwd_count            = cnt_q[1];
  assign stall_count          = cnt_q[2];
  assign control_hazard_count = cnt_q[3];
  assign branch_count         = cnt_q[4];
  assign jump_count           = cnt_q[5];
  assign mdu_stall_count      = cnt_q[6];

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Directed bench for cpu_hazard_ctrl: stimulus pushes hand-computed expectations into a queue,
// a negedge monitor pops and compares them against the DUT.
module tb_cpu_hazard_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned FWD_N  = 2;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 32;

  logic                    clk = 1'b0;
  logic                    clr;
  logic [REG_AW-1:0]       rd1_num, rd2_num;
  logic                    rd1_used, rd2_used, id_uses_mdu;
  logic [FWD_N*REG_AW-1:0] wr_num;
  logic [FWD_N-1:0]        wr_en, wr_late;
  logic                    mdu_start, redirect, redirect_jump;
  logic [SEL_W-1:0]        fwd1_sel, fwd2_sel;
  logic [4:0]              stalls, flushs;
  logic                    mdu_busy;
  logic [CNT_W-1:0]        dh_c, fw_c, st_c, ch_c, br_c, jp_c, ms_c;
  logic [SEL_W-1:0]        s_f1, s_f2;
  logic [4:0]              s_st, s_fl;
  logic                    s_busy;
  logic [3:0]              s_dh, s_fw, s_sc, s_ch, s_br, s_jp, s_ms;

  always #5 clk = ~clk;

  cpu_hazard_ctrl #(.REG_AW(REG_AW), .FWD_N(FWD_N), .SEL_W(SEL_W), .MDU_LAT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .rd1_num(rd1_num), .rd2_num(rd2_num), .rd1_used(rd1_used),
    .rd2_used(rd2_used), .id_uses_mdu(id_uses_mdu), .wr_num(wr_num), .wr_en(wr_en),
    .wr_late(wr_late), .mdu_start(mdu_start), .redirect(redirect),
    .redirect_jump(redirect_jump), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .stalls(stalls),
    .flushs(flushs), .mdu_busy(mdu_busy), .data_hazard_count(dh_c), .fwd_count(fw_c),
    .stall_count(st_c), .control_hazard_count(ch_c), .branch_count(br_c), .jump_count(jp_c),
    .mdu_stall_count(ms_c)
  );

  // Narrow-counter copy sharing the same stimulus, used for saturation.
  cpu_hazard_ctrl #(.REG_AW(REG_AW), .FWD_N(FWD_N), .SEL_W(SEL_W), .MDU_LAT(4), .CNT_W(4)) dut_sat (
    .clk(clk), .clr(clr), .rd1_num(rd1_num), .rd2_num(rd2_num), .rd1_used(rd1_used),
    .rd2_used(rd2_used), .id_uses_mdu(id_uses_mdu), .wr_num(wr_num), .wr_en(wr_en),
    .wr_late(wr_late), .mdu_start(mdu_start), .redirect(redirect),
    .redirect_jump(redirect_jump), .fwd1_sel(s_f1), .fwd2_sel(s_f2), .stalls(s_st),
    .flushs(s_fl), .mdu_busy(s_busy), .data_hazard_count(s_dh), .fwd_count(s_fw),
    .stall_count(s_sc), .control_hazard_count(s_ch), .branch_count(s_br), .jump_count(s_jp),
    .mdu_stall_count(s_ms)
  );

  typedef struct {
    string       nm;
    logic [1:0]  f1, f2;
    logic [4:0]  st, fl;
    logic        busy;
    int unsigned c0, c1, c2, c3, c4, c5, c6;
    int unsigned sfw;
  } exp_t;

  exp_t        q[$];
  int unsigned tot[7];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s got=%0d want=%0d", nm, fld, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "fwd1_sel", 32'(fwd1_sel), 32'(e.f1));
      chk(e.nm, "fwd2_sel", 32'(fwd2_sel), 32'(e.f2));
      chk(e.nm, "stalls", 32'(stalls), 32'(e.st));
      chk(e.nm, "flushs", 32'(flushs), 32'(e.fl));
      chk(e.nm, "mdu_busy", 32'(mdu_busy), 32'(e.busy));
      chk(e.nm, "data_hazard_count", dh_c, e.c0);
      chk(e.nm, "fwd_count", fw_c, e.c1);
      chk(e.nm, "stall_count", st_c, e.c2);
      chk(e.nm, "control_hazard_count", ch_c, e.c3);
      chk(e.nm, "branch_count", br_c, e.c4);
      chk(e.nm, "jump_count", jp_c, e.c5);
      chk(e.nm, "mdu_stall_count", ms_c, e.c6);
      chk(e.nm, "sat_fwd_count", 32'(s_fw), e.sfw);
    end
  end

  task automatic clear_in();
    clr = 1'b1; rd1_num = '0; rd2_num = '0; rd1_used = 1'b0; rd2_used = 1'b0;
    id_uses_mdu = 1'b0; wr_num = '0; wr_en = '0; wr_late = '0;
    mdu_start = 1'b0; redirect = 1'b0; redirect_jump = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  // inc bits: 0 data_hazard, 1 fwd, 2 stall, 3 control, 4 branch, 5 jump, 6 mdu_stall
  task automatic push(input string nm, input logic [1:0] f1, input logic [1:0] f2,
                      input logic [4:0] st, input logic [4:0] fl, input logic busy,
                      input logic [6:0] inc);
    exp_t e;
    e.nm = nm; e.f1 = f1; e.f2 = f2; e.st = st; e.fl = fl; e.busy = busy;
    e.c0 = tot[0]; e.c1 = tot[1]; e.c2 = tot[2]; e.c3 = tot[3];
    e.c4 = tot[4]; e.c5 = tot[5]; e.c6 = tot[6];
    e.sfw = (tot[1] > 15) ? 15 : tot[1];
    q.push_back(e);
    for (int i = 0; i < 7; i++) tot[i] = clr ? tot[i] + 32'(inc[i]) : 0;
  endtask

  initial begin
    clear_in();
    clr = 1'b0;
    for (int i = 0; i < 7; i++) tot[i] = 0;

    // Reset held with hazards on every input: all controls must be idle.
    cyc(); clr = 1'b0; rd1_num = 5; rd1_used = 1; rd2_num = 5; rd2_used = 1;
    wr_num = {5'd5, 5'd5}; wr_en = 2'b11; wr_late = 2'b01; mdu_start = 1;
    redirect = 1; redirect_jump = 1;
    push("rst_hold", 0, 0, 5'b00000, 5'b00000, 0, 7'b0000000);

    cyc(); rd1_num = 5; rd1_used = 1; wr_num = {5'd5, 5'd5}; wr_en = 2'b11;
    push("fwd_prio", 1, 0, 5'b00000, 5'b00000, 0, 7'b0000011);
    cyc(); rd1_num = 5; rd1_used = 1; wr_num = {5'd5, 5'd5}; wr_en = 2'b10;
    push("fwd_src1", 2, 0, 5'b00000, 5'b00000, 0, 7'b0000011);
    cyc(); rd1_num = 0; rd1_used = 1; wr_num = {5'd0, 5'd0}; wr_en = 2'b11;
    push("fwd_r0", 0, 0, 5'b00000, 5'b00000, 0, 7'b0000000);

    cyc(); rd2_num = 7; rd2_used = 1; wr_num = {5'd0, 5'd7}; wr_en = 2'b01; wr_late = 2'b01;
    push("lu_src0", 0, 0, 5'b00011, 5'b00100, 0, 7'b0000101);
    cyc(); rd2_num = 7; rd2_used = 1; wr_num = {5'd7, 5'd0}; wr_en = 2'b10;
    push("lu_next", 0, 2, 5'b00000, 5'b00000, 0, 7'b0000011);
    cyc(); rd1_num = 3; rd1_used = 1; rd2_num = 4; rd2_used = 1;
    wr_num = {5'd4, 5'd3}; wr_en = 2'b11;
    push("both_fwd", 1, 2, 5'b00000, 5'b00000, 0, 7'b0000011);

    cyc(); rd2_num = 7; rd2_used = 1; wr_num = {5'd0, 5'd7}; wr_en = 2'b01; wr_late = 2'b01;
    redirect = 1; redirect_jump = 1;
    push("redir_lu", 0, 0, 5'b00000, 5'b00110, 0, 7'b0101000);
    cyc(); redirect = 1;
    push("redir_br", 0, 0, 5'b00000, 5'b00110, 0, 7'b0011000);
    cyc();
    push("quiet", 0, 0, 5'b00000, 5'b00000, 0, 7'b0000000);

    cyc(); mdu_start = 1; id_uses_mdu = 1;
    push("mdu_c0", 0, 0, 5'b00000, 5'b00000, 0, 7'b0000000);
    for (int i = 1; i <= 4; i++) begin
      cyc(); id_uses_mdu = 1;
      push("mdu_busy", 0, 0, 5'b00011, 5'b00100, 1, 7'b1000100);
    end
    cyc(); id_uses_mdu = 1;
    push("mdu_rel", 0, 0, 5'b00000, 5'b00000, 0, 7'b0000000);

    // Start coinciding with a redirect, restart at cycle 2, load-use overlapping at cycle 3.
    cyc(); mdu_start = 1; id_uses_mdu = 1; redirect = 1;
    push("mdu_redir", 0, 0, 5'b00000, 5'b00110, 0, 7'b0011000);
    cyc(); id_uses_mdu = 1;
    push("rst_c1", 0, 0, 5'b00011, 5'b00100, 1, 7'b1000100);
    cyc(); id_uses_mdu = 1; mdu_start = 1;
    push("rst_c2", 0, 0, 5'b00011, 5'b00100, 1, 7'b1000100);
    cyc(); id_uses_mdu = 1; rd1_num = 9; rd1_used = 1; wr_num = {5'd0, 5'd9};
    wr_en = 2'b01; wr_late = 2'b01;
    push("lu_and_mdu", 0, 0, 5'b00011, 5'b00100, 1, 7'b1000101);
    for (int i = 4; i <= 6; i++) begin
      cyc(); id_uses_mdu = 1;
      push("restart_busy", 0, 0, 5'b00011, 5'b00100, 1, 7'b1000100);
    end
    cyc(); id_uses_mdu = 1;
    push("restart_rel", 0, 0, 5'b00000, 5'b00000, 0, 7'b0000000);

    // Reset mid-BUSY with counters nonzero.
    cyc(); mdu_start = 1;
    push("rb_c0", 0, 0, 5'b00000, 5'b00000, 0, 7'b0000000);
    cyc(); id_uses_mdu = 1;
    push("rb_c1", 0, 0, 5'b00011, 5'b00100, 1, 7'b1000100);
    cyc(); clr = 0; id_uses_mdu = 1; rd1_num = 5; rd1_used = 1; wr_num = {5'd5, 5'd5};
    wr_en = 2'b11; wr_late = 2'b01; redirect = 1;
    push("rb_low", 0, 0, 5'b00000, 5'b00000, 1, 7'b0000000);
    cyc(); id_uses_mdu = 1;
    push("rb_after", 0, 0, 5'b00000, 5'b00000, 0, 7'b0000000);

    for (int i = 0; i < 20; i++) begin
      cyc(); rd1_num = 5; rd1_used = 1; wr_num = {5'd0, 5'd5}; wr_en = 2'b01;
      push("sat_fwd", 1, 0, 5'b00000, 5'b00000, 0, 7'b0000011);
    end
    cyc();
    push("sat_hold", 0, 0, 5'b00000, 5'b00000, 0, 7'b0000000);

    cyc();
    repeat (2) @(posedge clk);
    chk("drain", "queue_left", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_hazard_ctrl.md
# cpu_hazard_ctrl

Parametrised hazard controller for the pipelined CPU. It generalises the fixed EX/MEM forwarding and stall/flush logic to a configurable number of forwarding source stages. It adds per-source load-use detection, a multi-cycle multiply/divide (MDU) interlock with its own busy counter, and saturating performance counters. It sits beside the stage modules in `cpu`: it takes register numbers from ID and write-back descriptors from later stages, and drives forwarding selects plus stall/flush masks into the stage latches.

## Interface
- `REG_AW`, 5, register number width
- `FWD_N`, 2, number of forwarding source stages; source 0 = EX, 1 = MEM, 2 = next stage, and so on
- `SEL_W`, $clog2(FWD_N+1), forwarding select width
- `MDU_LAT`, 4, MDU latency in cycles (≥1)
- `CNT_W`, 32, performance counter width
- `clk` in 1: the only clock, rising edge
- `clr` in 1: synchronous, active-low reset
- `rd1_num`, `rd2_num` in REG_AW: ID source register numbers
- `rd1_used`, `rd2_used` in 1: ID instruction actually reads that source
- `id_uses_mdu` in 1: ID instruction reads the MDU result (HI/LO)
- `wr_num` in FWD_N*REG_AW: destination register per source stage; slice k is source k
- `wr_en` in FWD_N: source k writes a register
- `wr_late` in FWD_N: source k's data is not yet available (load in that stage)
- `mdu_start` in 1: EX issues an MDU operation this cycle
- `redirect` in 1: EX resolved a taken branch or jump
- `redirect_jump` in 1: qualifies `redirect` (1 = jump, 0 = branch)
- `fwd1_sel`, `fwd2_sel` out SEL_W: 0 = register file; k+1 = source k
- `stalls` out 5: hold latch; bit0 IF, bit1 ID, bit2 EX, bit3 MEM, bit4 WB
- `flushs` out 5: bubble latch, same bit order
- `mdu_busy` out 1
- `data_hazard_count`, `fwd_count`, `stall_count`, `control_hazard_count`, `branch_count`, `jump_count`, `mdu_stall_count` out CNT_W

## Operation
- **Source match.** Source k matches operand i when all hold: `rd_i_used`, `wr_en[k]`, `wr_num[k]==rd_i_num`, and `rd_i_num!=0`. The lowest k (youngest) wins.
- **Forwarding.** Winning source k with `wr_late[k]=0` gives `fwd_i_sel=k+1`. No match gives 0.
- **Load-use.** If the winning source has `wr_late[k]=1`, load-use stall (`lu`) asserts. `fwd_i_sel` is then 0 and is don't-care.
- **MDU FSM.**
  - States: IDLE and BUSY, with a down-counter `mdu_cnt`.
  - IDLE + `mdu_start` → BUSY, `mdu_cnt=MDU_LAT-1`.
  - BUSY: decrement each cycle. At `mdu_cnt==0` → IDLE, unless `mdu_start` is asserted, which reloads `MDU_LAT-1` and stays BUSY.
  - `mdu_busy` = (state==BUSY).
  - `mdu_stall` = `mdu_busy & id_uses_mdu`.
- **Stall.** `stall_any` = `(lu | mdu_stall) & ~redirect`.
  - `stalls` = 5'b00011 when `stall_any`, else 0.
  - `flushs[2]` = `stall_any`, which inserts an EX bubble.
- **Redirect.** `redirect` forces `flushs[1]=1` and `flushs[2]=1`, and `stalls=0`. Redirect has priority over any stall because the instruction in ID is on the wrong path.
- **Counters.** Each counter saturates at all-ones and increments by 1 on each cycle its condition is true:
  - `fwd_count`: any `fwd_i_sel!=0` (both operands forwarded count 1).
  - `stall_count`: `stall_any`.
  - `mdu_stall_count`: `mdu_stall & ~redirect`.
  - `data_hazard_count`: any match on either operand, with `~redirect`.
  - `control_hazard_count`: `redirect`.
  - `branch_count`: `redirect & ~redirect_jump`.
  - `jump_count`: `redirect & redirect_jump`.

## Timing
- `fwd*_sel`, `stalls` and `flushs` are combinational from the current-cycle inputs and the FSM state. The stage latches sample them on the same rising edge.
- Counters and the MDU FSM update on the rising `clk` edge.
- **Reset (`clr=0` at a rising edge):**
  - All counters go to 0 and the FSM goes to IDLE, so `mdu_busy=0`.
  - Reset applies even mid-BUSY; an in-flight MDU interlock is dropped.
  - While `clr=0`, `stalls=0`, `flushs=0` and `fwd*_sel=0`, regardless of the other inputs.
- **Load-use.** A load in source 0 holds ID for exactly 1 cycle. Next cycle the load is in source 1 with `wr_late[1]=0`, so it forwards with `sel=2`.
- **MDU.** `mdu_start` at cycle t gives `mdu_busy` high for cycles t+1 … t+MDU_LAT.
  - `mdu_start` while BUSY restarts the count.
  - `mdu_start` and `redirect` in the same cycle: the MDU still starts.
- **Simultaneous events.**
  - `lu` and `mdu_stall` together count as one `stall_count` increment.
  - `redirect` with `lu` gives no stall and no stall count, but still flushes.

## Test plan
- **Forward priority.** FWD_N=2, `rd1_num=5`, sources 0 and 1 both writing r5, `wr_late=0` → `fwd1_sel=1`. Remove source 0 → `fwd1_sel=2`. Set `rd1_num=0` → `fwd1_sel=0`, and `data_hazard_count` does not increment.
- **Load-use.** `wr_late[0]=1` matching `rd2` → `stalls=00011`, `flushs=00100`, `stall_count` +1. Next cycle, source 1 matching with `wr_late[1]=0` → `fwd2_sel=2`, no stall.
- **MDU interlock.** MDU_LAT=4, `mdu_start` at cycle 0, `id_uses_mdu=1` held → stall on cycles 1-4, released at cycle 5, `mdu_stall_count=4`. A restart at cycle 2 extends the stall through cycle 6.
- **Redirect priority.** `redirect=1`, `redirect_jump=1` together with a load-use → `stalls=0`, `flushs=00110`, `jump_count` +1, `control_hazard_count` +1, `stall_count` unchanged.
- **Reset.** Assert `clr=0` mid-BUSY with counters nonzero → next edge gives all counters 0 and `mdu_busy=0`. During the low cycle `stalls`, `flushs` and `fwd*_sel` are 0.
- **Saturation.** CNT_W=4: 20 forwarding cycles → `fwd_count=15`, held there.
